mcpu_mem_arbiter: RTL and testbench
===================================

Name: mcpu_mem_arbiter

Overview:
Single-port RAM arbiter for the MCPU. It shares the 256-word instruction/data RAM between three requesters: instruction fetch, data load/store, and an external program loader. In run mode it round-robins between fetch and data. A load-mode FSM drains outstanding CPU accesses, stalls the CPU, and gives the loader exclusive RAM access. It sits between the MCPU core and the RAM instance.

Parameters:
WORD_SIZE, 16, RAM word and instruction width
ADDR_SIZE, 8, RAM address width (RAM_SIZE = 2**ADDR_SIZE)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
load_mode  in  1  1 = request loader session
cpu_stall  out  1  holds MCPU pipeline while loader owns RAM
f_req  in  1  fetch request (read only)
f_addr  in  ADDR_SIZE  fetch address
f_gnt  out  1  fetch grant pulse
f_rvalid  out  1  fetch read data valid
d_req  in  1  data request
d_we  in  1  data write enable
d_addr  in  ADDR_SIZE  data address
d_wdata  in  WORD_SIZE  data write word
d_gnt  out  1  data grant pulse
d_rvalid  out  1  data read data valid
l_req  in  1  loader request (write only)
l_addr  in  ADDR_SIZE  loader address
l_wdata  in  WORD_SIZE  loader write word
l_gnt  out  1  loader grant pulse
rdata  out  WORD_SIZE  read data, = ram_rdata passthrough
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_SIZE  RAM address
ram_wdata  out  WORD_SIZE  RAM write data
ram_rdata  in  WORD_SIZE  RAM read data, valid 1 cycle after ram_en

Behaviour:
- Reset (reset=0, async): all outputs 0, state RUN, round-robin pointer = data-first, outstanding-read flags cleared. Reset mid-access drops that access; no rvalid follows.
- Request rule: a requester holds req/addr/we/wdata stable until it sees gnt. It may drop or re-raise req on the cycle after gnt.
- Issue timing: requests sampled in cycle t. The winner's access is registered onto ram_en/ram_we/ram_addr/ram_wdata and its gnt pulses, both during cycle t+1. If the access is a read, the matching rvalid is high in t+2 and rdata is valid then.
- Double-grant guard: a requester whose gnt is high in the current cycle is masked from arbitration in that cycle. Different requesters can be granted back-to-back; the same requester is granted at most every other cycle.
- ram_en=0 whenever no grant is issued. ram_we/ram_addr/ram_wdata then hold their last values.
- RUN state:
  - Only f_req and d_req are eligible; l_req is ignored.
  - If both request, the pointer decides, then toggles toward the loser.
  - A single requester always wins; the pointer is unchanged on a single request.
- RUN -> DRAIN when load_mode=1 is sampled. No new CPU grants are issued from that cycle on, and cpu_stall=1.
- DRAIN -> LOAD once no read is outstanding (at most 1 cycle after the last grant).
- LOAD state:
  - Only l_req is eligible. Loader accesses are always writes: ram_we=1, ram_wdata=l_wdata.
  - cpu_stall=1.
- LOAD -> RUN on load_mode=0. cpu_stall deasserts in the first RUN cycle. The pointer resets to data-first.
- load_mode=0 during DRAIN: finish the drain, pass through LOAD for one cycle, then RUN. No loader grant is issued in that pass.
- An f_req/d_req raised during DRAIN/LOAD is held pending and is arbitrated normally in RUN.
- d_we=1 grants produce no d_rvalid. A fetch always produces f_rvalid.

Test Plan:
1. Reset while f_req=1 with a grant registered -> all outputs 0 immediately. After release, f_gnt fires 1 cycle later and no stale f_rvalid appears.
2. Fetch only:
   - Stimulus: f_req=1, f_addr=0x05, RAM[5]=0xA520.
   - Required: f_gnt and ram_en high in t+1 with ram_addr=0x05; f_rvalid=1 and rdata=0xA520 in t+2; next f_gnt no earlier than t+3.
3. Contention:
   - Stimulus: f_req=d_req=1 continuously from reset.
   - Required: grants alternate d, f, d, f at one per cycle; ram_en stays high.
4. Data write:
   - Stimulus: d_req=1, d_we=1, d_addr=0x10, d_wdata=0x1234.
   - Required: ram_we=1, ram_addr=0x10, ram_wdata=0x1234 with d_gnt; no d_rvalid; a later fetch of 0x10 returns 0x1234.
5. Load session:
   - Stimulus: load_mode rises while a fetch read is outstanding.
   - Required: f_rvalid still delivered and cpu_stall=1 from the next cycle; a loader write of 0x4420 to 0x00 lands; f_req is ignored until load_mode=0; cpu_stall drops one cycle after load_mode falls.
6. Loader ignored in RUN: l_req=1 with load_mode=0 -> l_gnt never asserts; fetch grants continue unaffected.

Source files
------------

// File: rtl/mcpu_mem_arbiter.sv
// Single-port RAM arbiter: fetch/data round-robin in run mode, exclusive loader access in load mode.
// Latency: grant and RAM strobe one cycle after request sample, read data valid the cycle after that.
// Backpressure: requesters hold req until gnt; CPU is stalled via cpu_stall while the loader owns RAM.
module mcpu_mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_mode,
  output logic                 cpu_stall,
  input  logic                 f_req,
  input  logic [ADDR_SIZE-1:0] f_addr,
  output logic                 f_gnt,
  output logic                 f_rvalid,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  input  logic                 l_req,
  input  logic [ADDR_SIZE-1:0] l_addr,
  input  logic [WORD_SIZE-1:0] l_wdata,
  output logic                 l_gnt,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   ptr_dfirst, ptr_nxt;
  logic   f_elig, d_elig, l_elig;
  logic   f_win, d_win, l_win;
  logic   rd_out;

  // A requester granted this cycle is still holding req, so mask it out.
  assign f_elig = f_req & ~f_gnt;
  assign d_elig = d_req & ~d_gnt;
  assign l_elig = l_req & ~l_gnt;

  // A read granted this cycle still owes its rvalid next cycle.
  assign rd_out = f_gnt | (d_gnt & ~ram_we);

  assign cpu_stall = (state != ST_RUN);
  assign rdata     = ram_rdata;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr_dfirst;
    f_win     = 1'b0;
    d_win     = 1'b0;
    l_win     = 1'b0;
    case (state)
      ST_RUN: begin
        if (load_mode) begin
          state_nxt = ST_DRAIN;
        end else if (f_elig && d_elig) begin
          if (ptr_dfirst) d_win = 1'b1;
          else            f_win = 1'b1;
          ptr_nxt = ~ptr_dfirst;
        end else if (f_elig) begin
          f_win = 1'b1;
        end else if (d_elig) begin
          d_win = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!rd_out) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // A session cancelled during drain passes through here with no loader grant.
        if (!load_mode) begin
          state_nxt = ST_RUN;
          ptr_nxt   = 1'b1;
        end else if (l_elig) begin
          l_win = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        ptr_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      ptr_dfirst <= 1'b1;
      f_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      l_gnt      <= 1'b0;
      f_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      ptr_dfirst <= ptr_nxt;
      f_gnt      <= f_win;
      d_gnt      <= d_win;
      l_gnt      <= l_win;
      ram_en     <= f_win | d_win | l_win;
      f_rvalid   <= f_gnt;
      d_rvalid   <= d_gnt & ~ram_we;
      if (f_win) begin
        ram_we   <= 1'b0;
        ram_addr <= f_addr;
      end else if (d_win) begin
        ram_we    <= d_we;
        ram_addr  <= d_addr;
        ram_wdata <= d_wdata;
      end else if (l_win) begin
        ram_we    <= 1'b1;
        ram_addr  <= l_addr;
        ram_wdata <= l_wdata;
      end
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({f_gnt, d_gnt, l_gnt}));
  a_f_spacing: assert property (@(posedge clk) disable iff (!reset)
    f_gnt |=> !f_gnt);
  a_d_spacing: assert property (@(posedge clk) disable iff (!reset)
    d_gnt |=> !d_gnt);

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Directed bench for mcpu_mem_arbiter with a behavioural single-port RAM.
module tb_mcpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_mode;
  logic        cpu_stall;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_gnt, f_rvalid;
  logic        d_req, d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic        l_req;
  logic [7:0]  l_addr;
  logic [15:0] l_wdata;
  logic        l_gnt;
  logic [15:0] rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'h0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  mcpu_mem_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(8)) dut (
    .clk(clk), .reset(reset), .load_mode(load_mode), .cpu_stall(cpu_stall),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // flags = {f_gnt, d_gnt, l_gnt, ram_en, f_rvalid, d_rvalid, cpu_stall}
  typedef struct {
    logic        fr;
    logic [7:0]  fa;
    logic        dr;
    logic        dw;
    logic [7:0]  da;
    logic [15:0] dd;
    logic        lr;
    logic [6:0]  flags;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic fr, input logic [7:0] fa, input logic dr,
                             input logic dw, input logic [7:0] da, input logic [15:0] dd,
                             input logic lr, input logic [6:0] flags, input logic we,
                             input logic [7:0] addr, input logic [15:0] wd,
                             input logic [15:0] rd);
    vec_t r;
    r.fr = fr; r.fa = fa; r.dr = dr; r.dw = dw; r.da = da; r.dd = dd; r.lr = lr;
    r.flags = flags; r.we = we; r.addr = addr; r.wd = wd; r.rd = rd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic cf(input string name, input logic [6:0] exp);
    chk(name, {25'd0, f_gnt, d_gnt, l_gnt, ram_en, f_rvalid, d_rvalid, cpu_stall}, {25'd0, exp});
  endtask

  task automatic cram(input string name, input logic we, input logic [7:0] a, input logic [15:0] wd);
    chk(name, {7'd0, ram_we, ram_addr, ram_wdata}, {7'd0, we, a, wd});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    l_req = 0; l_addr = 0; l_wdata = 0; load_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[5] = 16'hA520;

    idle_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    cf("reset_flags", 7'b0000000);
    cram("reset_ram", 1'b0, 8'h00, 16'h0000);

    // Contention from reset: data first, then strict alternation.
    f_req = 1; f_addr = 8'h01; d_req = 1; d_addr = 8'h02;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    cf("cont_c0", 7'b0000000);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c % 2 == 1) cf($sformatf("cont_c%0d_d", c), (c == 1) ? 7'b0101000 : 7'b0101100);
      else            cf($sformatf("cont_c%0d_f", c), 7'b1001010);
    end
    f_req = 0; d_req = 0;
    step();
    cf("cont_tail", 7'b0000100);
    step();

    // Reset while a fetch grant is registered.
    f_req = 1; f_addr = 8'h03;
    step();
    cf("rst_pre_gnt", 7'b1001000);
    #2 reset = 1'b0;
    #1;
    cf("rst_mid_flags", 7'b0000000);
    cram("rst_mid_ram", 1'b0, 8'h00, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    cf("rst_rel_noval", 7'b0000000);
    step();
    cf("rst_regrant", 7'b1001000);
    cram("rst_regrant_ram", 1'b0, 8'h03, 16'h0000);
    f_req = 0;
    step();
    cf("rst_rvalid", 7'b0000100);
    chk("rst_rdata", {16'd0, rdata}, 32'h1003);
    step();

    // Table: fetch only, data write then read-back, loader ignored in run, data read.
    tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 7'b0000000, 0, 8'h00, 16'h0000, 16'h0000));
    tbl.push_back(v(1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 7'b0000000, 0, 8'h00, 16'h0000, 16'h0000));
    tbl.push_back(v(1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 7'b1001000, 0, 8'h05, 16'h0000, 16'h0000));
    tbl.push_back(v(1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 7'b0000100, 0, 8'h00, 16'h0000, 16'hA520));
    tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 7'b1001000, 0, 8'h05, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 7'b0000100, 0, 8'h00, 16'h0000, 16'hA520));
    tbl.push_back(v(0, 8'h00, 1, 1, 8'h10, 16'h1234, 0, 7'b0000000, 0, 8'h00, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 8'h00, 1, 1, 8'h10, 16'h1234, 0, 7'b0101000, 1, 8'h10, 16'h1234, 16'h0000));
    tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 7'b0000000, 0, 8'h00, 16'h0000, 16'h0000));
    tbl.push_back(v(1, 8'h10, 0, 0, 8'h00, 16'h0000, 0, 7'b0000000, 0, 8'h00, 16'h0000, 16'h0000));
    tbl.push_back(v(1, 8'h10, 0, 0, 8'h00, 16'h0000, 0, 7'b1001000, 0, 8'h10, 16'h1234, 16'h0000));
    tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 7'b0000100, 0, 8'h00, 16'h0000, 16'h1234));
    tbl.push_back(v(1, 8'h07, 0, 0, 8'h00, 16'h0000, 1, 7'b0000000, 0, 8'h00, 16'h0000, 16'h0000));
    tbl.push_back(v(1, 8'h07, 0, 0, 8'h00, 16'h0000, 1, 7'b1001000, 0, 8'h07, 16'h1234, 16'h0000));
    tbl.push_back(v(1, 8'h07, 0, 0, 8'h00, 16'h0000, 1, 7'b0000100, 0, 8'h00, 16'h0000, 16'h1007));
    tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 7'b1001000, 0, 8'h07, 16'h1234, 16'h0000));
    tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 7'b0000100, 0, 8'h00, 16'h0000, 16'h1007));
    tbl.push_back(v(0, 8'h00, 1, 0, 8'h10, 16'h1234, 0, 7'b0000000, 0, 8'h00, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 8'h00, 1, 0, 8'h10, 16'h1234, 0, 7'b0101000, 0, 8'h10, 16'h1234, 16'h0000));
    tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 7'b0000010, 0, 8'h00, 16'h0000, 16'h1234));
    tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 7'b0000000, 0, 8'h00, 16'h0000, 16'h0000));

    for (int i = 0; i < tbl.size(); i++) begin
      f_req = tbl[i].fr; f_addr = tbl[i].fa;
      d_req = tbl[i].dr; d_we = tbl[i].dw; d_addr = tbl[i].da; d_wdata = tbl[i].dd;
      l_req = tbl[i].lr; l_addr = 8'h20; l_wdata = 16'hBEEF; load_mode = 0;
      cf($sformatf("row%0d_flags", i), tbl[i].flags);
      if (tbl[i].flags[3])
        cram($sformatf("row%0d_ram", i), tbl[i].we, tbl[i].addr, tbl[i].wd);
      if (tbl[i].flags[2] || tbl[i].flags[1])
        chk($sformatf("row%0d_rdata", i), {16'd0, rdata}, {16'd0, tbl[i].rd});
      step();
    end
    idle_inputs();

    // Load session entered while a fetch read is outstanding.
    f_req = 1; f_addr = 8'h05;
    step();
    cf("ld_A_gnt", 7'b1001000);
    load_mode = 1; f_req = 0;
    step();
    cf("ld_B_drain", 7'b0000101);
    chk("ld_B_rdata", {16'd0, rdata}, 32'hA520);
    f_req = 1; f_addr = 8'h06; l_req = 1; l_addr = 8'h00; l_wdata = 16'h4420;
    step();
    cf("ld_C_load", 7'b0000001);
    step();
    cf("ld_D_lgnt", 7'b0011001);
    cram("ld_D_ram", 1'b1, 8'h00, 16'h4420);
    l_req = 0;
    step();
    cf("ld_E_nofetch", 7'b0000001);
    step();
    cf("ld_F_nofetch", 7'b0000001);
    load_mode = 0;
    step();
    cf("ld_G_run", 7'b0000000);
    step();
    cf("ld_H_fgnt", 7'b1001000);
    cram("ld_H_ram", 1'b0, 8'h06, 16'h4420);
    f_req = 0;
    step();
    cf("ld_I_rvalid", 7'b0000100);
    chk("ld_I_rdata", {16'd0, rdata}, 32'h1006);
    f_req = 1; f_addr = 8'h00;
    step();
    cf("ld_rb_gnt", 7'b1001000);
    f_req = 0;
    step();
    chk("ld_rb_rdata", {16'd0, rdata}, 32'h4420);
    step();

    // load_mode pulse: drain, one pass through load with no loader grant, back to run.
    load_mode = 1; l_req = 1; l_addr = 8'h30; l_wdata = 16'hDEAD;
    step();
    cf("pulse_drain", 7'b0000001);
    load_mode = 0;
    step();
    cf("pulse_load", 7'b0000001);
    step();
    cf("pulse_run", 7'b0000000);
    l_req = 0;
    step();
    cf("pulse_idle", 7'b0000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
